instruction_cache: RTL and testbench
====================================

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 SHALL have parameter: INDEX_BITS, 3, index width (2^INDEX_BITS lines of 16 B); tag width = 6-INDEX_BITS.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: read  input  1  CPU fetch request.
REQ-005 SHALL have port: address  input  10  CPU byte address (PC).
REQ-006 SHALL have port: readinst  output  32  fetched instruction.
REQ-007 SHALL have port: busywait  output  1  CPU stall.
REQ-008 SHALL have port: mem_read  output  1  block read request to instruction memory.
REQ-009 SHALL have port: mem_address  output  6  block address to memory.
REQ-010 SHALL have port: mem_readinst  input  128  returned block, byte n at bits [8n+7:8n].
REQ-011 SHALL have port: mem_busywait  input  1  memory busy; rises with mem_read, falls when mem_readinst is valid.

Function
REQ-012 SHALL decode address: [1:0] ignored, [3:2] word offset, [3+INDEX_BITS:4] index, [9:4+INDEX_BITS] tag.
REQ-013 SHALL hold per line: valid bit, tag, 128-bit data block.
REQ-014 SHALL define hit = read & valid[index] & (tag[index]==addr tag), combinational.
REQ-015 SHALL drive readinst = word[offset] of indexed line combinationally; value on miss is don't-care.
REQ-016 SHALL implement FSM states IDLE, MEM_READ, UPDATE.
REQ-017 IDLE: busywait = read & ~hit; mem_read=0; on posedge with read & ~hit, latch tag/index to miss registers and go MEM_READ.
REQ-018 IDLE with read=0: busywait=0, no state change.
REQ-019 MEM_READ: mem_read=1, mem_address={latched tag, latched index}, busywait=1.
REQ-020 MEM_READ SHALL ignore mem_busywait on its first cycle; from second cycle on, posedge with mem_busywait=0 moves to UPDATE.
REQ-021 UPDATE: mem_read=0, busywait=1; on posedge write mem_readinst, latched tag, valid=1 into latched index; go IDLE.
REQ-022 After UPDATE the re-presented address SHALL hit in IDLE; miss penalty = memory busy cycles + 2 cycles.
REQ-023 Address changes while busywait=1 SHALL NOT alter the fill target (latched values used).
REQ-024 Hit latency SHALL be zero cycles (busywait never asserts on a hit).
REQ-025 Fill to an occupied line SHALL overwrite it (direct-mapped replacement).
REQ-026 read deasserted mid-miss SHALL NOT abort the fill; FSM completes to IDLE.

Reset
REQ-027 Reset at posedge SHALL force IDLE, clear all valid bits, clear miss registers.
REQ-028 Outputs during/after reset: busywait=0 (read=0) or 1 (read=1, all-miss), mem_read=0, mem_address=0.
REQ-029 Reset during MEM_READ or UPDATE SHALL drop mem_read next cycle and discard the fill.
REQ-030 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-031 Macro ICACHE_STATS_EN defined: add outputs hit_count[15:0], miss_count[15:0]; reset to 0.
REQ-032 With ICACHE_STATS_EN: hit_count +1 per posedge in IDLE with hit; miss_count +1 per IDLE->MEM_READ transition; both wrap 0xFFFF->0x0000.
REQ-033 Without ICACHE_STATS_EN: ports and counters absent; behaviour otherwise identical.

Verification
REQ-034 Reset, read=1, address=0x000 -> busywait=1, next cycle mem_read=1, mem_address=0; after mem_busywait falls, UPDATE, then readinst=mem_readinst[31:0], busywait=0.
REQ-035 After REQ-034 fill, address 0x004/0x008/0x00C -> busywait=0 same cycle, readinst = words 1/2/3 of the block.
REQ-036 INDEX_BITS=3: fill 0x000 then 0x080 (same index, tag 1) -> miss, mem_address=0x08; then 0x000 misses again.
REQ-037 Reset asserted second cycle of MEM_READ -> mem_read=0 next cycle, state IDLE, 0x000 misses afterwards.
REQ-038 Address toggled 0x010->0x3F0 during MEM_READ for 0x010 -> mem_address stays 0x01, line 1 filled with tag 0.
REQ-039 ICACHE_STATS_EN: 1 miss + 3 hits (REQ-034/035) -> miss_count=1, hit_count=4 (incl. post-fill hit); force 0xFFFF+1 -> 0x0000.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: 2^INDEX_BITS lines of 16 B, zero-latency hits, one-block fill on miss.
// Define ICACHE_STATS_EN to add the hit_count / miss_count outputs.
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  readinst,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  first_q, first_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_index_q, miss_index_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q [LINES];
  logic [127:0]          data_q [LINES];

  logic [1:0]            offset_s;
  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  hit_s;
  logic                  fill_s;
  logic [127:0]          line_s;
  logic                  unused_s;

  assign offset_s = address[3:2];
  assign index_s  = address[3+INDEX_BITS:4];
  assign tag_s    = address[9:4+INDEX_BITS];
  assign unused_s = ^address[1:0];

  // lookup: hit detection and word select from the indexed line
  always_comb begin
    line_s   = data_q[index_s];
    hit_s    = read & valid_q[index_s] & (tag_q[index_s] == tag_s);
    readinst = line_s[{offset_s, 5'd0} +: 32];
  end

  // miss FSM next state and outputs
  always_comb begin
    state_d      = state_q;
    first_d      = 1'b0;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    busywait     = 1'b0;
    mem_read     = 1'b0;
    mem_address  = 6'd0;
    fill_s       = 1'b0;
    case (state_q)
      IDLE: begin
        busywait = read & ~hit_s;
        if (read && !hit_s) begin
          state_d      = MEM_READ;
          first_d      = 1'b1;
          miss_tag_d   = tag_s;
          miss_index_d = index_s;
        end else begin
          state_d = IDLE;
        end
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {miss_tag_q, miss_index_q};
        // memory raises mem_busywait one edge after mem_read, so the first cycle is not trusted
        if (!first_q && !mem_busywait) begin
          state_d = UPDATE;
        end else begin
          state_d = MEM_READ;
        end
      end
      UPDATE: begin
        busywait = 1'b1;
        fill_s   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // valid bits set by a completed fill
  always_comb begin
    valid_d = valid_q;
    if (fill_s) begin
      valid_d[miss_index_q] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // control state, miss target and valid bits
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      first_q      <= 1'b0;
      miss_tag_q   <= {TAG_BITS{1'b0}};
      miss_index_q <= {INDEX_BITS{1'b0}};
      valid_q      <= {LINES{1'b0}};
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      valid_q      <= valid_d;
    end
  end

  // line storage; a write racing a reset is harmless because valid is cleared
  always_ff @(posedge clock) begin
    if (fill_s) begin
      tag_q[miss_index_q]  <= miss_tag_q;
      data_q[miss_index_q] <= mem_readinst;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // statistics counters, wrapping at 16 bits
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && hit_s) begin
      hit_count_d = hit_count_q + 16'd1;
    end else begin
      hit_count_d = hit_count_q;
    end
    if (state_q == IDLE && read && !hit_s) begin
      miss_count_d = miss_count_q + 16'd1;
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  // statistics registers
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios with literal expectations, then
// randomized fetches against a transaction-level cache model and a delayed-response memory.
module tb_instruction_cache;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  readinst;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinst;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  instruction_cache #(.INDEX_BITS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .readinst     (readinst),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit        drv_reset;
  bit        drv_read;
  logic [9:0] drv_addr;

  logic        s_busywait;
  logic        s_mem_read;
  logic [5:0]  s_mem_address;
  logic [31:0] s_readinst;

  // cache model: contents per line plus the progress of the outstanding miss
  bit           m_valid [8];
  int           m_tag   [8];
  logic [127:0] m_data  [8];
  int           m_phase;     // 0 no miss, 1 waiting on memory, 2 writing the block
  bit           m_first;
  int           m_ftag;
  int           m_fidx;
  int           m_hits;
  int           m_misses;

  // memory: answers a request after a random number of busy cycles
  bit         mem_active;
  int         busy_left;
  logic [5:0] mem_blk;

  function automatic logic [127:0] blk(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'hC0DE0000 | 32'(b << 4) | 32'(w);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    int idx, tg, wd;
    bit hit;
    @(negedge clock);
    reset        = drv_reset;
    read         = drv_read;
    address      = drv_addr;
    mem_busywait = mem_active && busy_left != 0;
    mem_readinst = (mem_active && busy_left == 0) ? blk(int'(mem_blk)) : {$urandom, $urandom, $urandom, $urandom};
    #1;
    s_busywait    = busywait;
    s_mem_read    = mem_read;
    s_mem_address = mem_address;
    s_readinst    = readinst;
    idx = (int'(address) >> 4) % 8;
    tg  = int'(address) >> 7;
    wd  = (int'(address) >> 2) % 4;
    hit = read && m_valid[idx] && (m_tag[idx] == tg);
    case (m_phase)
      0: begin
        chk("busywait_idle", busywait, read && !hit);
        chk("mem_read_idle", mem_read, 1'b0);
        if (hit) chk("readinst_hit", readinst, m_data[idx][wd*32 +: 32]);
      end
      1: begin
        chk("busywait_mem", busywait, 1'b1);
        chk("mem_read_mem", mem_read, 1'b1);
        chk("mem_address", mem_address, 6'(m_ftag * 8 + m_fidx));
      end
      default: begin
        chk("busywait_upd", busywait, 1'b1);
        chk("mem_read_upd", mem_read, 1'b0);
      end
    endcase
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 16'(m_hits));
    chk("miss_count", miss_count, 16'(m_misses));
`endif
    @(posedge clock);
    if (reset) begin
      m_phase = 0; m_first = 0; m_ftag = 0; m_fidx = 0; m_hits = 0; m_misses = 0;
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
    end else if (m_phase == 0) begin
      if (hit) m_hits++;
      else if (read) begin
        m_ftag = tg; m_fidx = idx; m_phase = 1; m_first = 1; m_misses++;
      end
    end else if (m_phase == 1) begin
      if (!m_first && !mem_busywait) m_phase = 2;
      m_first = 0;
    end else begin
      m_valid[m_fidx] = 1; m_tag[m_fidx] = m_ftag; m_data[m_fidx] = mem_readinst; m_phase = 0;
    end
    if (s_mem_read) begin
      if (!mem_active) begin
        mem_active = 1; mem_blk = s_mem_address; busy_left = int'($urandom_range(1, 4));
      end else if (busy_left > 0) busy_left--;
    end else mem_active = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      step();
      if (!s_busywait) break;
    end
    chk(name, s_busywait, 1'b0);
  endtask

  initial begin
    drv_reset = 1; drv_read = 0; drv_addr = 10'd0;
    reset = 1'b1; read = 1'b0; address = 10'd0; mem_busywait = 1'b0; mem_readinst = 128'd0;
    mem_active = 0; busy_left = 0; mem_blk = 6'd0;
    m_phase = 0; m_first = 0; m_ftag = 0; m_fidx = 0; m_hits = 0; m_misses = 0;
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    repeat (2) @(posedge clock);

    // outputs while held in reset
    step();
    chk("rst_busywait_r0", s_busywait, 1'b0);
    chk("rst_mem_address", s_mem_address, 6'h00);
    drv_read = 1;
    step();
    chk("rst_busywait_r1", s_busywait, 1'b1);
    chk("rst_mem_read", s_mem_read, 1'b0);
    drv_reset = 0; drv_read = 0;
    step();
    chk("post_rst_busywait", s_busywait, 1'b0);

    // cold miss on 0x000, fill, then word hits
    drv_read = 1; drv_addr = 10'h000;
    step();
    chk("miss0_busywait", s_busywait, 1'b1);
    chk("miss0_no_mem_read", s_mem_read, 1'b0);
    step();
    chk("miss0_mem_read", s_mem_read, 1'b1);
    chk("miss0_mem_address", s_mem_address, 6'h00);
    wait_idle("fill0_done");
    chk("fill0_word0", s_readinst, 32'hC0DE0000);
    drv_addr = 10'h004; step();
    chk("hit_w1_busy", s_busywait, 1'b0);
    chk("hit_w1", s_readinst, 32'hC0DE0001);
    drv_addr = 10'h008; step();
    chk("hit_w2", s_readinst, 32'hC0DE0002);
    drv_addr = 10'h00C; step();
    chk("hit_w3_busy", s_busywait, 1'b0);
    chk("hit_w3", s_readinst, 32'hC0DE0003);
`ifdef ICACHE_STATS_EN
    #1;
    chk("stats_hits4", hit_count, 16'd4);
    chk("stats_miss1", miss_count, 16'd1);
`endif

    // conflict on index 0: 0x080 evicts 0x000
    drv_addr = 10'h080; step();
    chk("conf_busywait", s_busywait, 1'b1);
    step();
    chk("conf_mem_address", s_mem_address, 6'h08);
    wait_idle("fill80_done");
    chk("fill80_word0", s_readinst, 32'hC0DE0080);
    drv_addr = 10'h000; step();
    chk("evicted_miss", s_busywait, 1'b1);
    wait_idle("refill0_done");

    // reset in the second MEM_READ cycle discards the fill
    drv_addr = 10'h010; step();
    step();
    chk("rstmid_mem_read", s_mem_read, 1'b1);
    drv_reset = 1; step();
    drv_reset = 0; drv_read = 0; step();
    chk("rstmid_dropped", s_mem_read, 1'b0);
    chk("rstmid_idle", s_busywait, 1'b0);
    drv_read = 1; drv_addr = 10'h000; step();
    chk("rstmid_cleared", s_busywait, 1'b1);
    wait_idle("refill0b_done");

    // address moves during the fill; target stays latched
    drv_addr = 10'h010; step();
    drv_addr = 10'h3F0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!s_mem_read) break;
      chk("latched_address", s_mem_address, 6'h01);
    end
    drv_addr = 10'h010; step();
    chk("latched_hit", s_busywait, 1'b0);
    chk("latched_data", s_readinst, 32'hC0DE0010);
    drv_addr = 10'h000; step();
    chk("line0_kept", s_busywait, 1'b0);

    // randomized fetch stream
    for (int n = 0; n < 2000; n++) begin
      drv_reset = ($urandom % 64) == 0;
      if (!(s_busywait && ($urandom % 4) != 0)) begin
        drv_read = ($urandom % 8) != 0;
        drv_addr = 10'(($urandom % 4) * 128 + ($urandom % 8) * 16 + ($urandom % 16));
      end else if (($urandom % 16) == 0) begin
        drv_read = 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
